// File: rtl/gps_code_nco_ctrl.sv
// Control FSM, chip/epoch counters and epoch-synchronous config handshake for a GPS code NCO.
// Optional macro CODE_NCO_CTRL_EPOCH_CNT_EN enables the 20 ms nav-bit epoch counter and bit_edge pulse.
module gps_code_nco_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [61:0] cfg_freq,
  input  logic [62:0] cfg_phase,
  input  logic        nco_enable,
  output logic        nco_rst,
  output logic        nco_send_en,
  output logic [61:0] nco_f_control,
  output logic [62:0] nco_phase_init,
  output logic [9:0]  chip_cnt,
  output logic        epoch,
  output logic [4:0]  epoch_cnt,
  output logic        bit_edge,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t      cur, nxt;
  logic        pending, pending_n;
  logic [61:0] shadow_freq;
  logic [62:0] shadow_phase;
  logic        tick, wrap, xfer, direct, apply;

  assign state = cur;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    if (start) nxt = LOAD;
      LOAD:    nxt = stop ? IDLE : RUN;
      RUN:     if (stop) nxt = IDLE; else if (start) nxt = LOAD;
      default: nxt = IDLE;
    endcase
  end

  assign tick   = nco_enable && (cur == RUN);
  assign wrap   = tick && (chip_cnt == 10'd1022);
  assign xfer   = cfg_valid && cfg_ready;
  // Outside RUN (or when leaving it for IDLE) a new config goes straight to the NCO registers.
  assign direct = (cur != RUN) || (nxt == IDLE);
  assign apply  = pending && (epoch || ((nxt == IDLE) && (cur != IDLE)));

  always_comb begin
    pending_n = pending;
    if (apply)                pending_n = 1'b0;
    else if (xfer && !direct) pending_n = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur            <= IDLE;
      nco_rst        <= 1'b0;
      nco_send_en    <= 1'b0;
      nco_f_control  <= '0;
      nco_phase_init <= '0;
      chip_cnt       <= '0;
      epoch          <= 1'b0;
      pending        <= 1'b0;
      cfg_ready      <= 1'b0;
    end else begin
      cur         <= nxt;
      nco_rst     <= (nxt == RUN);
      nco_send_en <= (nxt == RUN);
      pending     <= pending_n;
      cfg_ready   <= !pending_n;
      epoch       <= wrap;

      if (apply) begin
        nco_f_control  <= shadow_freq;
        nco_phase_init <= shadow_phase;
      end else if (xfer && direct) begin
        nco_f_control  <= cfg_freq;
        nco_phase_init <= cfg_phase;
      end

      if (nxt == LOAD)  chip_cnt <= '0;
      else if (wrap)    chip_cnt <= '0;
      else if (tick)    chip_cnt <= chip_cnt + 10'd1;
    end
  end

  // NOTE: the shadow is only ever read while pending is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (xfer && !direct) begin
      shadow_freq  <= cfg_freq;
      shadow_phase <= cfg_phase;
    end
  end

`ifdef CODE_NCO_CTRL_EPOCH_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      epoch_cnt <= '0;
      bit_edge  <= 1'b0;
    end else begin
      bit_edge <= wrap && (epoch_cnt == 5'd19);
      if (nxt == LOAD)
        epoch_cnt <= '0;
      else if (wrap)
        epoch_cnt <= (epoch_cnt == 5'd19) ? 5'd0 : epoch_cnt + 5'd1;
    end
  end
`else
  assign epoch_cnt = '0;
  assign bit_edge  = 1'b0;
`endif

endmodule

// File: tb/tb_gps_code_nco_ctrl.sv
// Directed bench for gps_code_nco_ctrl: vector table for FSM/config handshake, then hand-written
// sequences for epoch timing, epoch-synchronous update, stop/start, async reset and nav-bit counting.
module tb_gps_code_nco_ctrl;

  localparam logic [61:0] F61      = 62'd1 << 61;
  localparam logic [61:0] F60      = 62'd1 << 60;
  localparam logic [61:0] F_FAST   = {62{1'b1}};
  localparam logic [62:0] PH_ONES  = {63{1'b1}};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, stop = 1'b0, cfg_valid = 1'b0;
  logic [61:0] cfg_freq = '0;
  logic [62:0] cfg_phase = '0;
  logic        nco_enable;
  logic        cfg_ready, nco_rst, nco_send_en, epoch, bit_edge;
  logic [61:0] nco_f_control;
  logic [62:0] nco_phase_init;
  logic [9:0]  chip_cnt;
  logic [4:0]  epoch_cnt;
  logic [1:0]  state;

  gps_code_nco_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_freq(cfg_freq), .cfg_phase(cfg_phase),
    .nco_enable(nco_enable), .nco_rst(nco_rst), .nco_send_en(nco_send_en),
    .nco_f_control(nco_f_control), .nco_phase_init(nco_phase_init),
    .chip_cnt(chip_cnt), .epoch(epoch), .epoch_cnt(epoch_cnt), .bit_edge(bit_edge), .state(state)
  );

  always #5 clk = ~clk;

  // Code NCO model: phase accumulator whose carry is the chip tick.
  logic [63:0] acc;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              acc <= '0;
    else if (!nco_rst)     acc <= {1'b0, nco_phase_init};
    else if (nco_send_en)  acc <= {1'b0, acc[62:0]} + {2'b00, nco_f_control};
  end
  assign nco_enable = acc[63];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        start, stop, valid;
    logic [61:0] freq;
    logic [62:0] phase;
    logic [1:0]  st;
    logic        nrst, send, rdy;
    logic [61:0] f;
    logic [62:0] ph;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic p, input logic v,
                              input logic [61:0] fr, input logic [62:0] pi,
                              input logic [1:0] st, input logic nr, input logic se, input logic rd,
                              input logic [61:0] f, input logic [62:0] ph);
    vec_t r;
    r.start = s; r.stop = p; r.valid = v; r.freq = fr; r.phase = pi;
    r.st = st; r.nrst = nr; r.send = se; r.rdy = rd; r.f = f; r.ph = ph;
    return r;
  endfunction

  vec_t tbl[11];

  // Bench expectations for counters
  logic [9:0] exp_chip  = '0;
  logic [4:0] exp_ecnt  = '0;
  logic       exp_epoch = 1'b0;
  logic       exp_bedge = 1'b0;
  logic       in_run    = 1'b0;
  int         dut_epochs = 0;
  int         dut_bedges = 0;

  task automatic check_reset(input string tag);
    check({tag, " state"},     64'(state), 64'd0);
    check({tag, " nco_rst"},   64'(nco_rst), 64'd0);
    check({tag, " send_en"},   64'(nco_send_en), 64'd0);
    check({tag, " f_control"}, 64'(nco_f_control), 64'd0);
    check({tag, " phase"},     64'(nco_phase_init), 64'd0);
    check({tag, " chip_cnt"},  64'(chip_cnt), 64'd0);
    check({tag, " epoch"},     64'(epoch), 64'd0);
    check({tag, " epoch_cnt"}, 64'(epoch_cnt), 64'd0);
    check({tag, " bit_edge"},  64'(bit_edge), 64'd0);
    check({tag, " cfg_ready"}, 64'(cfg_ready), 64'd0);
  endtask

  // One clock; clear models LOAD entry. Checks counters against the bench model.
  task automatic run_cycle(input logic clear);
    logic t;
    t = nco_enable;
    @(posedge clk);
    @(negedge clk);
    exp_epoch = 1'b0;
    exp_bedge = 1'b0;
    if (clear) begin
      exp_chip = '0;
      exp_ecnt = '0;
    end else if (t && in_run) begin
      if (exp_chip == 10'd1022) begin
        exp_chip  = '0;
        exp_epoch = 1'b1;
`ifdef CODE_NCO_CTRL_EPOCH_CNT_EN
        if (exp_ecnt == 5'd19) begin
          exp_ecnt  = '0;
          exp_bedge = 1'b1;
        end else begin
          exp_ecnt = exp_ecnt + 5'd1;
        end
`endif
      end else begin
        exp_chip = exp_chip + 10'd1;
      end
    end
    if (epoch)    dut_epochs++;
    if (bit_edge) dut_bedges++;
    check("chip_cnt",  64'(chip_cnt),  64'(exp_chip));
    check("epoch",     64'(epoch),     64'(exp_epoch));
    check("epoch_cnt", 64'(epoch_cnt), 64'(exp_ecnt));
    check("bit_edge",  64'(bit_edge),  64'(exp_bedge));
  endtask

  task automatic do_start();
    start = 1'b1;
    run_cycle(1'b1);
    start = 1'b0;
    check("start state LOAD", 64'(state), 64'd1);
    check("start nco_rst low", 64'(nco_rst), 64'd0);
    run_cycle(1'b0);
    check("start state RUN", 64'(state), 64'd2);
    check("start nco_rst high", 64'(nco_rst), 64'd1);
    check("start send_en high", 64'(nco_send_en), 64'd1);
    in_run = 1'b1;
  endtask

  initial begin
    int cycles;
    int ep0;
    tbl[0]  = mk(0, 0, 0, 62'd0, 63'd0,     2'd0, 0, 0, 1, 62'd0, 63'd0);
    tbl[1]  = mk(0, 0, 1, 62'd3, PH_ONES,   2'd0, 0, 0, 1, 62'd3, PH_ONES);
    tbl[2]  = mk(0, 1, 0, 62'd0, 63'd0,     2'd0, 0, 0, 1, 62'd3, PH_ONES);
    tbl[3]  = mk(1, 0, 0, 62'd0, 63'd0,     2'd1, 0, 0, 1, 62'd3, PH_ONES);
    tbl[4]  = mk(0, 1, 0, 62'd0, 63'd0,     2'd0, 0, 0, 1, 62'd3, PH_ONES);
    tbl[5]  = mk(1, 0, 0, 62'd0, 63'd0,     2'd1, 0, 0, 1, 62'd3, PH_ONES);
    tbl[6]  = mk(0, 0, 1, F61,   63'd0,     2'd2, 1, 1, 1, F61,   63'd0);
    tbl[7]  = mk(0, 0, 1, F60,   63'h55,    2'd2, 1, 1, 0, F61,   63'd0);
    tbl[8]  = mk(0, 0, 1, 62'd7, 63'd0,     2'd2, 1, 1, 0, F61,   63'd0);
    tbl[9]  = mk(0, 1, 0, 62'd0, 63'd0,     2'd0, 0, 0, 1, F60,   63'h55);
    tbl[10] = mk(0, 0, 1, F61,   63'd0,     2'd0, 0, 0, 1, F61,   63'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      start = tbl[i].start; stop = tbl[i].stop; cfg_valid = tbl[i].valid;
      cfg_freq = tbl[i].freq; cfg_phase = tbl[i].phase;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
      check($sformatf("v%0d state", i),     64'(state),          64'(tbl[i].st));
      check($sformatf("v%0d nco_rst", i),   64'(nco_rst),        64'(tbl[i].nrst));
      check($sformatf("v%0d send_en", i),   64'(nco_send_en),    64'(tbl[i].send));
      check($sformatf("v%0d cfg_ready", i), 64'(cfg_ready),      64'(tbl[i].rdy));
      check($sformatf("v%0d f_control", i), 64'(nco_f_control),  64'(tbl[i].f));
      check($sformatf("v%0d phase", i),     64'(nco_phase_init), 64'(tbl[i].ph));
    end

    // First epoch at freq 2^61: a tick every 4 cycles, epoch visible 4*1023+1 cycles into RUN.
    do_start();
    cycles = 0;
    ep0 = dut_epochs;
    while (cycles < 5000 && !exp_epoch) begin
      run_cycle(1'b0);
      cycles++;
    end
    check("first epoch cycle", 64'(cycles), 64'd4093);
    check("first epoch count", 64'(dut_epochs - ep0), 64'd1);

    // Frequency change requested at chip 100 waits for the epoch.
    cycles = 0;
    while (cycles < 600 && exp_chip != 10'd100) begin
      run_cycle(1'b0);
      cycles++;
    end
    cfg_valid = 1'b1; cfg_freq = F60; cfg_phase = 63'h0ABC;
    run_cycle(1'b0);
    cfg_valid = 1'b0;
    check("pend cfg_ready low", 64'(cfg_ready), 64'd0);
    check("pend f_control old", 64'(nco_f_control), 64'(F61));
    cycles = 0;
    ep0 = dut_epochs;
    while (cycles < 5000 && !exp_epoch) begin
      run_cycle(1'b0);
      cycles++;
    end
    check("pend epoch count", 64'(dut_epochs - ep0), 64'd1);
    check("epoch f_control old", 64'(nco_f_control), 64'(F61));
    check("epoch cfg_ready low", 64'(cfg_ready), 64'd0);
    check("epoch phase old", 64'(nco_phase_init), 64'd0);
    run_cycle(1'b0);
    check("post f_control new", 64'(nco_f_control), 64'(F60));
    check("post cfg_ready high", 64'(cfg_ready), 64'd1);
    check("post phase new", 64'(nco_phase_init), 64'h0ABC);

    // stop+start together in RUN: stop wins, chip_cnt freezes; a later start reloads.
    repeat (30) run_cycle(1'b0);
    start = 1'b1; stop = 1'b1;
    run_cycle(1'b0);
    start = 1'b0; stop = 1'b0;
    in_run = 1'b0;
    check("stop state IDLE", 64'(state), 64'd0);
    check("stop send_en low", 64'(nco_send_en), 64'd0);
    check("stop nco_rst low", 64'(nco_rst), 64'd0);
    check("stop chip nonzero", 64'(chip_cnt != 10'd0), 64'd1);
    repeat (10) run_cycle(1'b0);
    do_start();
    repeat (20) run_cycle(1'b0);

    // Async reset mid-RUN with a pending update.
    cfg_valid = 1'b1; cfg_freq = 62'h2_0000_1234; cfg_phase = 63'd5;
    run_cycle(1'b0);
    cfg_valid = 1'b0;
    check("pre-reset cfg_ready", 64'(cfg_ready), 64'd0);
    #2 rst = 1'b0;
    #1 check_reset("async");
    @(negedge clk);
    rst = 1'b1;
    in_run = 1'b0;
    exp_chip = '0;
    exp_ecnt = '0;
    run_cycle(1'b0);
    check("rel cfg_ready", 64'(cfg_ready), 64'd1);
    check("rel f_control", 64'(nco_f_control), 64'd0);
    check("rel state", 64'(state), 64'd0);
    do_start();
    stop = 1'b1;
    run_cycle(1'b0);
    stop = 1'b0;
    in_run = 1'b0;
    check("rel stop f_control", 64'(nco_f_control), 64'd0);
    check("rel stop phase", 64'(nco_phase_init), 64'd0);

`ifdef CODE_NCO_CTRL_EPOCH_CNT_EN
    // 20 epochs at near-maximum frequency: epoch_cnt 1..19 then 0 with one bit_edge.
    cfg_valid = 1'b1; cfg_freq = F_FAST; cfg_phase = 63'd0;
    run_cycle(1'b0);
    cfg_valid = 1'b0;
    check("fast f_control", 64'(nco_f_control), 64'(F_FAST));
    do_start();
    ep0 = dut_epochs;
    dut_bedges = 0;
    cycles = 0;
    while (cycles < 50000 && (dut_epochs - ep0) < 20) begin
      run_cycle(1'b0);
      cycles++;
    end
    check("nav epochs", 64'(dut_epochs - ep0), 64'd20);
    check("nav bit_edges", 64'(dut_bedges), 64'd1);
    check("nav epoch_cnt wrap", 64'(epoch_cnt), 64'd0);
`else
    check("no-macro bit_edges", 64'(dut_bedges), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gps_code_nco_ctrl.md
GPS_CODE_NCO_CTRL -- requirements
Module: gps_code_nco_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: start  in  1  pulse, (re)load phase and run; stop  in  1  pulse, halt NCO.
REQ-004 SHALL have ports: cfg_valid  in  1; cfg_ready  out  1; cfg_freq  in  62  code frequency word; cfg_phase  in  63  initial code phase.
REQ-005 SHALL have ports: nco_enable  in  1  chip tick from code NCO (accumulator carry, one cycle high per chip).
REQ-006 SHALL have ports: nco_rst  out  1  active-low load to NCO; nco_send_en  out  1; nco_f_control  out  62; nco_phase_init  out  63.
REQ-007 SHALL have ports: chip_cnt  out  10; epoch  out  1  1-cycle pulse per 1023 chips; epoch_cnt  out  5; bit_edge  out  1; state  out  2.

Function
REQ-008 SHALL implement FSM IDLE(0), LOAD(1), RUN(2); encoding visible on state.
REQ-009 IDLE: nco_rst=0, nco_send_en=0; start -> LOAD.
REQ-010 LOAD: exactly one cycle, nco_rst=0, nco_phase_init=active phase; chip_cnt, epoch_cnt cleared; -> RUN.
REQ-011 RUN: nco_rst=1, nco_send_en=1; stop -> IDLE next cycle; start (no stop) -> LOAD (re-phase).
REQ-012 stop SHALL take priority over start in the same cycle; stop in IDLE/LOAD SHALL be ignored in IDLE and abort LOAD to IDLE.
REQ-013 Chip tick = nco_enable high while state==RUN; ticks in IDLE/LOAD SHALL be ignored.
REQ-014 chip_cnt SHALL increment per tick, wrapping 1022 -> 0; epoch SHALL be high the cycle after the tick that wraps it.
REQ-015 Config handshake: transfer when cfg_valid && cfg_ready; cfg_ready is registered, =1 when no update pending.
REQ-016 Transfer in IDLE or LOAD SHALL update active freq and phase directly (visible next cycle); no pending set.
REQ-017 Transfer in RUN SHALL store freq+phase in shadow, set pending, drop cfg_ready next cycle.
REQ-018 Pending freq SHALL be copied to nco_f_control on the cycle epoch is asserted; pending cleared; cfg_ready=1 next cycle; shadow phase copied to active phase (used at next LOAD only).
REQ-019 Transition to IDLE SHALL apply any pending shadow immediately and clear pending.
REQ-020 nco_f_control and nco_phase_init SHALL be registered and never change except per REQ-016/018/019.

Reset
REQ-021 rst low SHALL asynchronously force: state=IDLE, nco_rst=0, nco_send_en=0, nco_f_control=0, nco_phase_init=0, chip_cnt=0, epoch=0, epoch_cnt=0, bit_edge=0, pending=0, cfg_ready=0.
REQ-022 cfg_ready SHALL rise the first cycle after rst deasserts; reset mid-RUN discards pending config.

Configuration
REQ-023 Macro CODE_NCO_CTRL_EPOCH_CNT_EN defined: epoch_cnt increments per epoch, wraps 19 -> 0; bit_edge pulses with the epoch that wraps it (20 ms nav bit).
REQ-024 Macro undefined: epoch_cnt and bit_edge tied 0; all other behaviour identical.

Verification (bench NCO model: acc<=phase_init when nco_rst=0, else acc<=acc[62:0]+f when send_en; nco_enable=acc[63])
REQ-025 Reset then cfg freq=2^61, phase=0, start -> LOAD 1 cycle, RUN; nco_enable every 4 cycles; chip_cnt 0..1022; epoch 1 cycle after 1023rd tick.
REQ-026 In RUN, cfg freq=2^60 at chip 100 -> cfg_ready low next cycle; nco_f_control stays 2^61 until epoch, 2^60 thereafter; cfg_ready high cycle after.
REQ-027 stop and start same cycle in RUN -> IDLE, nco_send_en=0, chip_cnt frozen; second start -> LOAD, chip_cnt=0.
REQ-028 rst pulsed low mid-RUN with pending -> all outputs reset values immediately; after release, nco_f_control=0, pending cleared.
REQ-029 With CODE_NCO_CTRL_EPOCH_CNT_EN, 20 epochs -> epoch_cnt 0..19 -> 0, single bit_edge; without macro epoch_cnt=0, bit_edge=0.
